// File: rtl/lut_bank_pkg.sv
// Shared types and defaults for the multi-table lookup memory.
package lut_bank_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } lut_state_e;

  localparam int LUT_WIDTH_DEF     = 8;
  localparam int LUT_ADDR_BITS_DEF = 9;
  localparam int LUT_DEPTH_DEF     = 360;
  localparam int LUT_N_TABLES_DEF  = 2;

  // Low bit of table t inside the concatenated read bus.
  function automatic int slice_lo(input int t, input int width);
    return t * width;
  endfunction

endpackage

// File: rtl/lut_bank_mem_if.sv
// Read/write/clear bus of the lookup memory; slave is the memory side.
interface lut_bank_mem_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 9,
  parameter int N_TABLES  = 2
);
  logic                      enable_I;
  logic [ADDR_BITS-1:0]      R_addr;
  logic                      enable_O;
  logic [N_TABLES*WIDTH-1:0] O_data;
  logic [N_TABLES-1:0]       WE;
  logic [ADDR_BITS-1:0]      W_addr;
  logic [WIDTH-1:0]          I_data;
  logic                      clear_req;
  logic [WIDTH-1:0]          clear_val;
  logic                      busy;
  logic                      wr_err;

  modport slave (
    input  enable_I, R_addr, WE, W_addr, I_data, clear_req, clear_val,
    output enable_O, O_data, busy, wr_err
  );

  modport master (
    output enable_I, R_addr, WE, W_addr, I_data, clear_req, clear_val,
    input  enable_O, O_data, busy, wr_err
  );
endinterface

// File: rtl/lut_bank_table.sv
// One 1R1W synchronous-read table. LUT_WR_FWD_EN selects write-first
// (forward same-address write data) instead of read-first behaviour.
module lut_bank_table #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 9,
  parameter int DEPTH     = 360
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [WIDTH-1:0]     rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read mux, optionally bypassing a same-cycle write to the read address.
  always_comb begin
    rdata_d = mem_q[raddr];
`ifdef LUT_WR_FWD_EN
    if (we && (waddr == raddr)) begin
      rdata_d = wdata;
    end else begin
      rdata_d = mem_q[raddr];
    end
`endif
  end

  // Output register holds its value between read requests.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lut_bank_mem.sv
// N_TABLES parallel lookup tables with shared read address and a clear engine.
// Define LUT_WR_FWD_EN for write-first same-address behaviour.
module lut_bank_mem
  import lut_bank_pkg::*;
#(
  parameter int WIDTH     = LUT_WIDTH_DEF,
  parameter int ADDR_BITS = LUT_ADDR_BITS_DEF,
  parameter int DEPTH     = LUT_DEPTH_DEF,
  parameter int N_TABLES  = LUT_N_TABLES_DEF
) (
  input logic           clock,
  input logic           reset,
  lut_bank_mem_if.slave bus
);

  localparam logic [ADDR_BITS:0]   DEPTH_X   = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  lut_state_e                state_q, state_d;
  logic [ADDR_BITS-1:0]      clr_addr_q, clr_addr_d;
  logic [WIDTH-1:0]          fill_q, fill_d;
  logic                      busy_q, busy_d;
  logic                      wr_err_q, wr_err_d;
  logic                      en_o_q, en_o_d;
  logic                      zero_q, zero_d;
  logic                      w_in_range_s, r_in_range_s, wr_any_s;
  logic [N_TABLES-1:0]       tab_we_s;
  logic [ADDR_BITS-1:0]      tab_waddr_s;
  logic [WIDTH-1:0]          tab_wdata_s;
  logic [N_TABLES*WIDTH-1:0] rd_data_s;

  // Extra MSB keeps the compare correct when DEPTH == 2**ADDR_BITS.
  assign w_in_range_s = ({1'b0, bus.W_addr} < DEPTH_X);
  assign r_in_range_s = ({1'b0, bus.R_addr} < DEPTH_X);
  assign wr_any_s     = |bus.WE;

  // Clear sequencer next state.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    fill_d     = fill_q;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clear_req) begin
          state_d    = ST_CLEAR;
          clr_addr_d = '0;
          fill_d     = bus.clear_val;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_BITS'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Write arbitration: the clear owns every table while busy.
  always_comb begin
    tab_we_s    = '0;
    tab_waddr_s = bus.W_addr;
    tab_wdata_s = bus.I_data;
    if (busy_q) begin
      tab_we_s    = '1;
      tab_waddr_s = clr_addr_q;
      tab_wdata_s = fill_q;
    end else if (w_in_range_s) begin
      tab_we_s = bus.WE;
    end else begin
      tab_we_s = '0;
    end
    wr_err_d = wr_any_s && (!w_in_range_s || busy_q);
    en_o_d   = bus.enable_I;
    zero_d   = bus.enable_I ? (busy_q || !r_in_range_s) : zero_q;
  end

  // Control and status registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      clr_addr_q <= '0;
      fill_q     <= '0;
      busy_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      en_o_q     <= 1'b0;
      zero_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      fill_q     <= fill_d;
      busy_q     <= busy_d;
      wr_err_q   <= wr_err_d;
      en_o_q     <= en_o_d;
      zero_q     <= zero_d;
    end
  end

  for (genvar t = 0; t < N_TABLES; t++) begin : g_tab
    localparam int LO = slice_lo(t, WIDTH);
    lut_bank_table #(
      .WIDTH     (WIDTH),
      .ADDR_BITS (ADDR_BITS),
      .DEPTH     (DEPTH)
    ) u_table (
      .clk   (clock),
      .we    (tab_we_s[t]),
      .waddr (tab_waddr_s),
      .wdata (tab_wdata_s),
      .re    (bus.enable_I),
      .raddr (bus.R_addr),
      .rdata (rd_data_s[LO +: WIDTH])
    );
  end

  assign bus.enable_O = en_o_q;
  assign bus.busy     = busy_q;
  assign bus.wr_err   = wr_err_q;
  assign bus.O_data   = zero_q ? '0 : rd_data_s;

endmodule

// File: tb/tb_lut_bank_mem.sv
// Randomised scoreboard bench for lut_bank_mem against an array-based model.
module tb_lut_bank_mem;

  localparam int DEPTH = 360;
  localparam int NT    = 2;

  typedef struct packed {
    logic en;
    logic busy;
    logic werr;
  } cyc_t;

  logic clock = 1'b0;
  logic reset = 1'b1;

  lut_bank_mem_if #(.WIDTH(8), .ADDR_BITS(9), .N_TABLES(NT)) bus ();

  lut_bank_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          started  = 1'b0;
  logic [15:0] rd_q [$];
  cyc_t        cyc_q [$];

  logic [7:0]  mdl [NT][512];
  bit          m_busy = 1'b0;
  int          m_pos  = 0;
  logic [7:0]  m_fill = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT outputs against queued expectations each cycle.
  logic [15:0] last_data = 16'h0000;
  always @(posedge clock) begin
    cyc_t        c;
    logic [15:0] d;
    #1;
    if (reset) begin
      last_data = 16'h0000;
    end else if (started) begin
      if (cyc_q.size() == 0) begin
        chk("cycle_queue_underflow", 32'd0, 32'd1);
      end else begin
        c = cyc_q.pop_front();
        chk("enable_O", {31'd0, bus.enable_O}, {31'd0, c.en});
        chk("busy", {31'd0, bus.busy}, {31'd0, c.busy});
        chk("wr_err", {31'd0, bus.wr_err}, {31'd0, c.werr});
      end
      if (bus.enable_O) begin
        if (rd_q.size() == 0) begin
          chk("read_queue_underflow", 32'd0, 32'd1);
        end else begin
          d = rd_q.pop_front();
          chk("O_data", {16'd0, bus.O_data}, {16'd0, d});
          last_data = d;
        end
      end else begin
        chk("O_data_hold", {16'd0, bus.O_data}, {16'd0, last_data});
      end
    end
  end

  // One clock of stimulus; the model applies the same edge from the rules.
  task automatic step(input logic en, input logic [8:0] raddr, input logic [1:0] we,
                      input logic [8:0] waddr, input logic [7:0] wdata,
                      input logic creq, input logic [7:0] cval);
    bit          busy_now;
    bit          acc;
    logic [15:0] exp;
    logic [7:0]  v;
    bus.enable_I  = en;
    bus.R_addr    = raddr;
    bus.WE        = we;
    bus.W_addr    = waddr;
    bus.I_data    = wdata;
    bus.clear_req = creq;
    bus.clear_val = cval;
    busy_now = m_busy;
    acc = (we != 2'b00) && !busy_now && (int'(waddr) < DEPTH);
    if (en) begin
      exp = 16'h0000;
      if (!busy_now && int'(raddr) < DEPTH) begin
        for (int t = 0; t < NT; t++) begin
          v = mdl[t][raddr];
`ifdef LUT_WR_FWD_EN
          if (acc && we[t] && waddr == raddr) v = wdata;
`endif
          exp[t*8 +: 8] = v;
        end
      end
      rd_q.push_back(exp);
    end
    if (acc) begin
      for (int t = 0; t < NT; t++) if (we[t]) mdl[t][waddr] = wdata;
    end
    if (busy_now) begin
      for (int t = 0; t < NT; t++) mdl[t][m_pos] = m_fill;
      m_pos++;
      if (m_pos == DEPTH) m_busy = 1'b0;
    end else if (creq) begin
      m_busy = 1'b1;
      m_pos  = 0;
      m_fill = cval;
    end
    cyc_q.push_back('{en: en, busy: m_busy,
                      werr: (we != 2'b00) && ((int'(waddr) >= DEPTH) || busy_now)});
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 9'd0, 2'b00, 9'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [8:0] a);
    step(1'b1, a, 2'b00, 9'd0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [1:0] we, input logic [8:0] a, input logic [7:0] d);
    step(1'b0, 9'd0, we, a, d, 1'b0, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.enable_I = 1'b0; bus.R_addr = '0; bus.WE = '0; bus.W_addr = '0;
    bus.I_data = '0; bus.clear_req = 1'b0; bus.clear_val = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_enable_O", {31'd0, bus.enable_O}, 32'd0);
    chk("rst_O_data", {16'd0, bus.O_data}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_wr_err", {31'd0, bus.wr_err}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    started = 1'b1;

    // Directed load and read-back at address 5.
    wr(2'b01, 9'd5, 8'hA5);
    wr(2'b10, 9'd5, 8'h3C);
    rd(9'd5);
    // Out-of-range write and read.
    wr(2'b11, 9'd360, 8'hFF);
    rd(9'd360);
    idle();

    // Clear to 0x11 while probing a write and reads during busy.
    step(1'b0, 9'd0, 2'b00, 9'd0, 8'h00, 1'b1, 8'h11);
    n = 0;
    while (bus.busy && n < 1000) begin
      if (n == 5) wr(2'b11, 9'd20, 8'h99);
      else step(1'b1, 9'($urandom_range(0, 370)), 2'b00, 9'd0, 8'h00, 1'b1, 8'h42);
      n++;
    end
    chk("clear_busy_cycles", n, DEPTH);
    rd(9'd0); rd(9'd180); rd(9'd359); rd(9'd20);

    // Randomised traffic, occasionally including a clear.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom % 2), 9'($urandom_range(0, 370)), 2'($urandom % 4),
           9'($urandom_range(0, 370)), 8'($urandom),
           1'($urandom % 150 == 0), 8'($urandom));
    end
    n = 0;
    while (m_busy && n < 1000) begin
      idle();
      n++;
    end

    // Same-cycle write and read at address 9.
    wr(2'b11, 9'd9, 8'h01);
    step(1'b1, 9'd9, 2'b01, 9'd9, 8'h77, 1'b0, 8'h00);
    rd(9'd9);

    // Reset in the middle of a clear.
    wr(2'b11, 9'd200, 8'h5A);
    wr(2'b11, 9'd50, 8'h33);
    step(1'b0, 9'd0, 2'b00, 9'd0, 8'h00, 1'b1, 8'hEE);
    repeat (100) idle();
    reset = 1'b1;
    m_busy = 1'b0;
    #1;
    chk("midclear_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("midclear_rst_O_data", {16'd0, bus.O_data}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    rd(9'd50); rd(9'd200); rd(9'd99); rd(9'd100);
    repeat (3) idle();

    chk("read_queue_drained", rd_q.size(), 32'd0);
    chk("cycle_queue_drained", cyc_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lut_bank_mem.md
# lut_bank_mem

Parametrised multi-table lookup memory for the backlight-dimming datapath, generalising the fixed two-table 8-bit × 512 ROM/RAM pair. It holds N_TABLES independent tables that are read in parallel at one shared address, with one-cycle latency and a delayed read-enable. A single write port carries a per-table write-enable. A built-in clear engine sweeps all valid entries to a fill value on request.

## Interface
- WIDTH, 8: bits per entry.
- ADDR_BITS, 9: address width.
- DEPTH, 360: valid entries per table; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_BITS.
- N_TABLES, 2: number of tables.
- clock  in  1  sole clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- enable_I  in  1  read request.
- R_addr  in  ADDR_BITS  read address, shared by all tables.
- enable_O  out  1  read data valid; this is enable_I delayed by 1 cycle.
- O_data  out  N_TABLES*WIDTH  read data; table t occupies bits [t*WIDTH +: WIDTH].
- WE  in  N_TABLES  per-table write enable; several bits may be high at once.
- W_addr  in  ADDR_BITS  write address.
- I_data  in  WIDTH  write data, common to all enabled tables.
- clear_req  in  1  single-cycle pulse that starts a clear.
- clear_val  in  WIDTH  fill value, sampled together with clear_req.
- busy  out  1  high while a clear is running.
- wr_err  out  1  one-cycle pulse when a write is rejected.

## Operation
- FSM states are IDLE and CLEAR; reset forces IDLE.
- IDLE → CLEAR on clear_req. On the same edge: clr_addr←0, fill←clear_val, busy←1.
- In CLEAR, every cycle writes fill to clr_addr in all tables, then increments clr_addr.
  - When the write to DEPTH-1 completes, the FSM returns to IDLE and busy←0.
  - clear_req is ignored while in CLEAR.
- External write: each table t with WE[t]=1, W_addr<DEPTH and busy=0 is written with I_data.
  - A write with any WE bit set is dropped entirely if W_addr≥DEPTH or busy=1. The drop produces a wr_err pulse on the next cycle.
- Read: when enable_I=1, every table is sampled at R_addr.
  - If R_addr≥DEPTH, that read returns 0.
  - If busy=1 at the request edge, the read returns 0 for all tables.
  - When enable_I=0, O_data holds its previous value.
- enable_O follows enable_I every cycle, whatever the busy state.
- Memory contents are not reset and have no defined initial value; software runs a clear or loads the tables first.

## Timing
- Reset values: enable_O=0, O_data=0, busy=0, wr_err=0, FSM=IDLE, clr_addr=0.
- Read latency is 1 cycle: a request at edge k gives enable_O=1 and O_data valid after edge k.
- Throughput is one read per cycle, with no stalls.
- A clear lasts exactly DEPTH cycles. busy is high from the edge after clear_req to the edge after the last fill write.
- Write on the clear_req cycle: the FSM is still IDLE, so the write is accepted; the clear later overwrites that entry.
- Same-cycle read and write at the same address: see Configuration.
- Reset mid-clear: the FSM returns to IDLE immediately and busy drops. Entries below clr_addr are already cleared; the rest keep their contents.
- clr_addr is a wrapping counter of ADDR_BITS bits, but the FSM stops at DEPTH-1, so it never wraps in use.

## Configuration
- LUT_WR_FWD_EN defined (write-first): a read and an accepted write to the same address, for the same table, in the same cycle returns I_data on O_data the next cycle.
- LUT_WR_FWD_EN undefined (read-first): the same read returns the old stored value.
- Forwarding is per table and applies only where WE[t]=1.

## Structure
- Package lut_bank_pkg holds:
  - the FSM state enum (ST_IDLE, ST_CLEAR);
  - default parameter constants;
  - a helper function computing the O_data slice offset.
- Sub-module lut_bank_table is one table: single-clock, 1R1W, synchronous-read inferred RAM, including the forwarding mux. It is instantiated N_TABLES times by generate.
- The top level holds the FSM, the address range checks, the write arbitration between clear and external writes, the enable_O register and the zero-forcing of O_data.

## Test plan
- Reset, then write 0xA5 to table 0 at address 5 and 0x3C to table 1 at address 5, then read address 5 → next cycle enable_O=1, O_data[7:0]=0xA5, O_data[15:8]=0x3C.
- Write to W_addr=360 with DEPTH=360 → wr_err pulses once; a read of address 360 returns 0 for both tables.
- clear_req with clear_val=0x11 → busy high for exactly 360 cycles; afterwards addresses 0, 180 and 359 read 0x11; a write during busy raises wr_err and leaves the entry at 0x11.
- Assert reset at clear cycle 100 → busy=0 immediately; address 50 reads the fill value; address 200 keeps its prior contents.
- Same-cycle write of 0x77 and read at address 9, old value 0x01 → reads 0x77 with LUT_WR_FWD_EN defined and 0x01 without it.
